// File: rtl/arith_encoder_param.sv
// Parametrised arithmetic (range) encoder with a programmable cumulative-count
// table, E3 pending-bit handling and a flow-controlled serial code stream.
//
// Ports:
//   sys_clk, sys_reset          clock, synchronous active-high reset
//   sym_in/sym_valid/sym_ready  symbol handshake (sym_err flags dropped symbols)
//   tbl_we/tbl_addr/tbl_data    cumulative table write, honoured in IDLE only
//   bit_out/bit_valid/bit_ready serial code bit handshake, bit_last on final bit
//   done                        one-cycle pulse after the block's last bit
//   busy                        high whenever the encoder is not IDLE
module arith_encoder_param #(
    parameter int PREC        = 10,
    parameter int NUM_SYM     = 5,
    parameter int SYM_W       = 3,
    parameter int CNT_W       = 8,
    parameter int TOTAL_COUNT = 96,
    parameter int BLOCK_LEN   = 96,
    parameter int PEND_W      = 7
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic             tbl_we,
    input  logic [SYM_W-1:0] tbl_addr,
    input  logic [CNT_W-1:0] tbl_data,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_last,
    output logic             done,
    output logic             sym_err,
    output logic             busy
);

    localparam int SC_W = $clog2(BLOCK_LEN + 1);
    localparam int PW   = PREC + 1 + CNT_W;

    localparam logic [PREC-1:0]   HALF = {1'b1, {(PREC-1){1'b0}}};
    localparam logic [PREC-1:0]   QTR  = {2'b01, {(PREC-2){1'b0}}};
    localparam logic [PREC-1:0]   THQ  = {2'b11, {(PREC-2){1'b0}}};
    localparam logic [PREC-1:0]   TOP  = '1;
    localparam logic [PEND_W-1:0] PMAX = '1;
    localparam logic [SC_W-1:0]   BLK  = SC_W'(BLOCK_LEN);
    localparam logic [SYM_W:0]    NSYM = (SYM_W+1)'(NUM_SYM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_UPDATE,
        S_RENORM,
        S_EMIT,
        S_FLUSH,
        S_FLUSH_EMIT,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [PREC-1:0]   low_q;
    logic [PREC-1:0]   high_q;
    logic [PEND_W-1:0] pend_q;
    logic [SC_W-1:0]   sc_q;
    logic [SYM_W-1:0]  sym_q;
    logic              qbit_q;
    logic              first_q;
    logic [CNT_W-1:0]  cum_q [0:NUM_SYM];

    logic              sym_ok;
    logic              tbl_ok;
    logic              emit_last;
    logic [PREC:0]     range_w;
    logic [PW-1:0]     prod_hi;
    logic [PW-1:0]     prod_lo;
    logic [PREC-1:0]   low_d;
    logic [PREC-1:0]   high_d;
    logic [PEND_W-1:0] pend_inc;

    function automatic logic [CNT_W-1:0] rst_cum(input int i);
        case (i)
            0:       return '0;
            1:       return CNT_W'(2);
            2:       return CNT_W'(71);
            3:       return CNT_W'(90);
            4:       return CNT_W'(94);
            default: return CNT_W'(TOTAL_COUNT);
        endcase
    endfunction

    assign sym_ok = {1'b0, sym_in} < NSYM;
    assign tbl_ok = {1'b0, tbl_addr} <= NSYM;

    // Interval update; both bounds derive from the pre-update low.
    assign range_w = {1'b0, high_q} - {1'b0, low_q} + (PREC+1)'(1);
    assign prod_hi = PW'(range_w) * PW'(cum_q[sym_q + SYM_W'(1)]);
    assign prod_lo = PW'(range_w) * PW'(cum_q[sym_q]);
    assign high_d  = PREC'(PW'(low_q) + prod_hi / PW'(TOTAL_COUNT) - PW'(1));
    assign low_d   = PREC'(PW'(low_q) + prod_lo / PW'(TOTAL_COUNT));

    assign pend_inc = (pend_q == PMAX) ? pend_q : pend_q + PEND_W'(1);

    // Queued bit goes out first, then one complement per pending count.
    assign emit_last = first_q ? (pend_q == '0) : (pend_q == PEND_W'(1));

    always_comb begin
        state_d   = state_q;
        sym_ready = 1'b0;
        bit_valid = 1'b0;
        bit_last  = 1'b0;
        done      = 1'b0;
        sym_err   = 1'b0;
        busy      = (state_q != S_IDLE);
        bit_out   = first_q ? qbit_q : ~qbit_q;
        unique case (state_q)
            S_IDLE: state_d = S_ACCEPT;
            S_ACCEPT: begin
                sym_ready = 1'b1;
                sym_err   = sym_valid && !sym_ok;
                if (sym_valid && sym_ok)
                    state_d = S_UPDATE;
            end
            S_UPDATE: state_d = S_RENORM;
            S_RENORM: begin
                if (high_q < HALF || low_q >= HALF)
                    state_d = S_EMIT;
                else if (low_q >= QTR && high_q < THQ)
                    state_d = S_RENORM;
                else if (sc_q == BLK)
                    state_d = S_FLUSH;
                else
                    state_d = S_ACCEPT;
            end
            S_EMIT: begin
                bit_valid = 1'b1;
                if (bit_ready && emit_last)
                    state_d = S_RENORM;
            end
            S_FLUSH: state_d = S_FLUSH_EMIT;
            S_FLUSH_EMIT: begin
                bit_valid = 1'b1;
                bit_last  = emit_last;
                if (bit_ready && emit_last)
                    state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q <= S_IDLE;
            low_q   <= '0;
            high_q  <= TOP;
            pend_q  <= '0;
            sc_q    <= '0;
            sym_q   <= '0;
            qbit_q  <= 1'b0;
            first_q <= 1'b1;
            for (int i = 0; i <= NUM_SYM; i++)
                cum_q[i] <= rst_cum(i);
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (tbl_we && tbl_ok)
                        cum_q[tbl_addr] <= tbl_data;
                end
                S_ACCEPT: begin
                    if (sym_valid && sym_ok) begin
                        sym_q <= sym_in;
                        sc_q  <= sc_q + SC_W'(1);
                    end
                end
                S_UPDATE: begin
                    low_q  <= low_d;
                    high_q <= high_d;
                end
                S_RENORM: begin
                    if (high_q < HALF) begin
                        qbit_q  <= 1'b0;
                        first_q <= 1'b1;
                        low_q   <= low_q << 1;
                        high_q  <= (high_q << 1) | PREC'(1);
                    end else if (low_q >= HALF) begin
                        qbit_q  <= 1'b1;
                        first_q <= 1'b1;
                        low_q   <= (low_q - HALF) << 1;
                        high_q  <= ((high_q - HALF) << 1) | PREC'(1);
                    end else if (low_q >= QTR && high_q < THQ) begin
                        pend_q  <= pend_inc;
                        low_q   <= (low_q - QTR) << 1;
                        high_q  <= ((high_q - QTR) << 1) | PREC'(1);
                    end
                end
                S_EMIT, S_FLUSH_EMIT: begin
                    if (bit_ready) begin
                        if (first_q)
                            first_q <= 1'b0;
                        else
                            pend_q <= pend_q - PEND_W'(1);
                    end
                end
                S_FLUSH: begin
                    pend_q  <= pend_inc;
                    qbit_q  <= (low_q >= QTR);
                    first_q <= 1'b1;
                end
                S_DONE: begin
                    low_q  <= '0;
                    high_q <= TOP;
                    sc_q   <= '0;
                    pend_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/arith_encoder_param.md
Name: arith_encoder_param

Overview:
- Parametrised arithmetic (range) encoder; successor to the fixed 6-symbol / 96-count encoder in the arithmetic_coding path.
- Consumes a block of BLOCK_LEN symbols through a valid/ready handshake and encodes them against a run-time programmable cumulative-count table.
- Emits the code as a flow-controlled serial bit stream, with E3 (underflow) pending-bit handling and end-of-block flush.
- Sits between the symbol quantiser and the serialiser/link framer.

Parameters:
- PREC, 10, width of the low/high interval registers; HALF = 2^(PREC-1), QTR = 2^(PREC-2).
- NUM_SYM, 5, number of symbols; the table has NUM_SYM+1 entries.
- SYM_W, 3, symbol index width.
- CNT_W, 8, cumulative-count entry width.
- TOTAL_COUNT, 96, table total; must satisfy TOTAL_COUNT <= QTR.
- BLOCK_LEN, 96, symbols per block.
- PEND_W, 7, pending (E3) counter width.

Ports:
- sys_clk  in  1  clock.
- sys_reset  in  1  synchronous active-high reset.
- sym_in  in  SYM_W  symbol index.
- sym_valid  in  1  symbol present.
- sym_ready  out  1  encoder accepts symbol.
- tbl_we  in  1  table write strobe; honoured in IDLE only.
- tbl_addr  in  SYM_W  table entry (0..NUM_SYM).
- tbl_data  in  CNT_W  cumulative count.
- bit_out  out  1  code bit.
- bit_valid  out  1  bit_out valid.
- bit_ready  in  1  downstream accepts bit.
- bit_last  out  1  qualifies the final bit of the block.
- done  out  1  one-cycle pulse after the last bit is accepted.
- sym_err  out  1  one-cycle pulse when an out-of-range symbol is dropped.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: low=0, high=2^PREC-1, pending=0, sym_cnt=0, state IDLE.
- Reset outputs: sym_ready=0, bit_valid=0, bit_last=0, done=0, sym_err=0, busy=0.
- Reset table: 0,2,71,90,94,96 (entries 0..5).
- Reset mid-operation aborts the block and discards partial output.
- States: IDLE, ACCEPT, UPDATE, RENORM, EMIT, FLUSH, FLUSH_EMIT, DONE.
- IDLE:
  - Table writes are accepted here; tbl_we in any other state is ignored.
  - Goes to ACCEPT the cycle after reset deasserts.
- ACCEPT:
  - sym_ready=1.
  - On sym_valid with sym_in < NUM_SYM: latch the symbol, sym_cnt++, go to UPDATE.
  - sym_in >= NUM_SYM: pulse sym_err, drop the symbol, stay in ACCEPT; it does not count toward BLOCK_LEN.
- UPDATE (1 cycle), with range = high-low+1 (PREC+1 bits) and products of PREC+1+CNT_W bits, floor division by TOTAL_COUNT:
  - high' = low + range*cum[s+1]/TOTAL_COUNT - 1.
  - low' = low + range*cum[s]/TOTAL_COUNT.
  - Both are computed from the old low. Go to RENORM.
- RENORM: one step per cycle.
  - high<HALF: queue bit 0, go to EMIT.
  - low>=HALF: queue bit 1, subtract HALF from low and high, go to EMIT.
  - low>=QTR and high<HALF+QTR: pending++, subtract QTR from both.
  - After any of the three cases: low=2*low, high=2*high+1.
  - None of the three: go to ACCEPT, or to FLUSH if sym_cnt==BLOCK_LEN.
- EMIT:
  - Present the queued bit b, then pending copies of !b, one per bit_ready handshake; pending decrements per accepted complement bit.
  - Return to RENORM when pending==0 and the last bit is accepted.
  - bit_valid is held with bit_out stable while bit_ready=0; no bit is ever dropped or duplicated.
- FLUSH:
  - pending++.
  - Queue 0 if low<QTR, else 1.
  - FLUSH_EMIT sends it plus pending complements; bit_last is asserted with the final bit.
- DONE: pulse done for one cycle, then go to IDLE with low/high/sym_cnt reinitialised. The table is retained.
- Pending overflow: pending saturates at 2^PEND_W-1.
- Throughput: one symbol is accepted at most every 2 cycles plus renormalisation/emit cycles.

Test Plan:
- Reset table, BLOCK_LEN=1, symbol 0, bit_ready=1 -> stream 0,0,0,0,0,0,1 (7 bits), bit_last on the 7th bit, done one cycle later.
- Reset table, BLOCK_LEN=1, symbol 1 -> UPDATE gives low=21, high=756, no renorm; flush stream 0,1.
- Write table 0,24,72,90,94,96 in IDLE, BLOCK_LEN=1, symbol 1 -> low=256, high=767 gives one E3 step (pending=1); flush stream 0,1,1.
- Symbol 1 with bit_ready toggling 1,0,0,1 per cycle -> same 0,1 stream; bit_out stable while stalled; exactly 2 handshakes.
- Symbol 7 (>= NUM_SYM) in ACCEPT -> sym_err pulse, sym_cnt unchanged; a following valid symbol is encoded normally.
- sys_reset asserted mid-EMIT -> next cycle bit_valid=0, busy=0, low=0, high=1023; tbl_we during UPDATE leaves the table unchanged.
